// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with write-through bypass and load scoreboard
//   clk, rst           : clock, asynchronous active-high reset
//   rad_a/rad_b        : read addresses -> rd_a/rd_b data, busy_a/busy_b pending-load flags
//   we/wad/wd          : ALU write port (wins over the load port on the same address)
//   lwe/lwad/lwd       : load writeback port, also clears the scoreboard entry
//   claim/claim_ad     : marks a register as waiting on an issued load
//   wcol               : registered pulse, both write ports hit one address last cycle
//   err                : sticky protocol error flag
module regfile_sb #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 4,
    parameter int AW       = $clog2(DEPTH),
    parameter int ZERO_REG = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    rad_a,
    input  logic [AW-1:0]    rad_b,
    output logic [WIDTH-1:0] rd_a,
    output logic [WIDTH-1:0] rd_b,
    output logic             busy_a,
    output logic             busy_b,
    input  logic             we,
    input  logic [AW-1:0]    wad,
    input  logic [WIDTH-1:0] wd,
    input  logic             lwe,
    input  logic [AW-1:0]    lwad,
    input  logic [WIDTH-1:0] lwd,
    input  logic             claim,
    input  logic [AW-1:0]    claim_ad,
    output logic             wcol,
    output logic             err
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] pending;
    logic             we_e, lwe_e, claim_e, err_n;
    // Gating with rst keeps the bypass path quiet while reset is held; gating
    // address 0 keeps register 0 at its reset value, so reads of it return 0.
    assign we_e    = we && !rst && !(ZERO_REG != 0 && wad == '0);
    assign lwe_e   = lwe && !rst && !(ZERO_REG != 0 && lwad == '0);
    assign claim_e = claim && !rst && !(ZERO_REG != 0 && claim_ad == '0);
    assign rd_a = (we_e && wad == rad_a) ? wd : (lwe_e && lwad == rad_a) ? lwd : mem[rad_a];
    assign rd_b = (we_e && wad == rad_b) ? wd : (lwe_e && lwad == rad_b) ? lwd : mem[rad_b];
    // A load returning this cycle already supplies its data through the bypass.
    assign busy_a = pending[rad_a] && !(lwe_e && lwad == rad_a);
    assign busy_b = pending[rad_b] && !(lwe_e && lwad == rad_b);
    assign err_n = (lwe_e && !pending[lwad])
                || (claim_e && pending[claim_ad] && !(lwe_e && lwad == claim_ad))
                || (we_e && pending[wad]);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            pending <= '0;
            wcol    <= 1'b0;
            err     <= 1'b0;
        end else begin
            // Later assignments win: ALU data over load data, claim over clear.
            if (lwe_e) mem[lwad] <= lwd;
            if (we_e) mem[wad] <= wd;
            if (lwe_e) pending[lwad] <= 1'b0;
            if (claim_e) pending[claim_ad] <= 1'b1;
            wcol <= we_e && lwe_e && wad == lwad;
            err  <= err || err_n;
        end
    end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: table-driven scoreboard bench for regfile_sb (ZERO_REG=0 and ZERO_REG=1 instances)
module tb_regfile_sb;
    logic clk = 1'b0;
    logic rst, we, lwe, claim;
    logic [1:0] rad_a, rad_b, wad, lwad, claim_ad;
    logic [15:0] wd, lwd;
    logic [15:0] rd_a, rd_b, rd_a_z, rd_b_z;
    logic busy_a, busy_b, wcol, err, busy_a_z, busy_b_z, wcol_z, err_z;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    regfile_sb #(.WIDTH(16), .DEPTH(4), .ZERO_REG(0)) dut (
        .clk(clk), .rst(rst), .rad_a(rad_a), .rad_b(rad_b), .rd_a(rd_a), .rd_b(rd_b),
        .busy_a(busy_a), .busy_b(busy_b), .we(we), .wad(wad), .wd(wd),
        .lwe(lwe), .lwad(lwad), .lwd(lwd), .claim(claim), .claim_ad(claim_ad),
        .wcol(wcol), .err(err));

    regfile_sb #(.WIDTH(16), .DEPTH(4), .ZERO_REG(1)) dut_z (
        .clk(clk), .rst(rst), .rad_a(rad_a), .rad_b(rad_b), .rd_a(rd_a_z), .rd_b(rd_b_z),
        .busy_a(busy_a_z), .busy_b(busy_b_z), .we(we), .wad(wad), .wd(wd),
        .lwe(lwe), .lwad(lwad), .lwd(lwd), .claim(claim), .claim_ad(claim_ad),
        .wcol(wcol_z), .err(err_z));

    typedef struct {
        logic r, z, we;
        logic [1:0] wad;
        logic [15:0] wd;
        logic lwe;
        logic [1:0] lwad;
        logic [15:0] lwd;
        logic claim;
        logic [1:0] cad, ra, rb;
        logic [15:0] ea, eb;
        logic eba, ebb, ewc, eer;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    function automatic vec_t mk(input logic r, z, w, input logic [1:0] wa, input logic [15:0] d,
                                input logic l, input logic [1:0] la, input logic [15:0] ld,
                                input logic c, input logic [1:0] ca, ra, rb,
                                input logic [15:0] ea, eb, input logic ba, bb, wc, er);
        vec_t v;
        v.r = r; v.z = z; v.we = w; v.wad = wa; v.wd = d; v.lwe = l; v.lwad = la; v.lwd = ld;
        v.claim = c; v.cad = ca; v.ra = ra; v.rb = rb; v.ea = ea; v.eb = eb;
        v.eba = ba; v.ebb = bb; v.ewc = wc; v.eer = er;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    // Drive at the falling edge, push the expectation, compare 2ns later (well before the rising edge).
    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        rst = v.r; we = v.we; wad = v.wad; wd = v.wd; lwe = v.lwe; lwad = v.lwad; lwd = v.lwd;
        claim = v.claim; claim_ad = v.cad; rad_a = v.ra; rad_b = v.rb;
        exp_q.push_back(v);
        #2;
        e = exp_q.pop_front();
        chk(e.z ? "rd_a_z" : "rd_a", idx, e.z ? rd_a_z : rd_a, e.ea);
        chk(e.z ? "rd_b_z" : "rd_b", idx, e.z ? rd_b_z : rd_b, e.eb);
        chk(e.z ? "busy_a_z" : "busy_a", idx, {15'd0, e.z ? busy_a_z : busy_a}, {15'd0, e.eba});
        chk(e.z ? "busy_b_z" : "busy_b", idx, {15'd0, e.z ? busy_b_z : busy_b}, {15'd0, e.ebb});
        chk(e.z ? "wcol_z" : "wcol", idx, {15'd0, e.z ? wcol_z : wcol}, {15'd0, e.ewc});
        chk(e.z ? "err_z" : "err", idx, {15'd0, e.z ? err_z : err}, {15'd0, e.eer});
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; we = 0; lwe = 0; claim = 0; wad = 0; lwad = 0; claim_ad = 0;
        rad_a = 0; rad_b = 0; wd = 0; lwd = 0;
        //            r  z  we wa wd        lwe la lwd      c  ca ra rb ea        eb        ba bb wc er
        tbl.push_back(mk(1, 0, 1, 2, 16'h1111, 0, 0, 16'h0000, 0, 0, 2, 0, 16'h0000, 16'h0000, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 2, 1, 16'h0000, 16'h0000, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 2, 3, 16'h0000, 16'h0000, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 2, 16'hBEEF, 0, 0, 16'h0000, 0, 0, 2, 3, 16'hBEEF, 16'h0000, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 2, 2, 16'hBEEF, 16'hBEEF, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 1, 2, 1, 16'hBEEF, 16'h0000, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 1, 1, 16'h0000, 16'h0000, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 1, 1, 16'h0000, 16'h0000, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 1, 16'h1234, 0, 0, 1, 1, 16'h1234, 16'h1234, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 1, 1, 16'h1234, 16'h1234, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 3, 3, 0, 16'h0000, 16'h0000, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 3, 16'hAAAA, 1, 3, 16'h5555, 0, 0, 3, 3, 16'hAAAA, 16'hAAAA, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 3, 3, 16'hAAAA, 16'hAAAA, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 3, 3, 16'hAAAA, 16'hAAAA, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 1, 1, 16'h7777, 0, 0, 16'h0000, 1, 2, 1, 2, 16'h0000, 16'h0000, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 1, 2, 16'h0000, 16'h0000, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 2, 2, 2, 16'h0000, 16'h0000, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 2, 16'h4444, 1, 2, 2, 2, 16'h4444, 16'h4444, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 2, 2, 16'h4444, 16'h4444, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 2, 16'h5555, 0, 0, 2, 2, 16'h5555, 16'h5555, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 2, 2, 16'h5555, 16'h5555, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 0, 16'h0101, 0, 0, 0, 0, 16'h0101, 16'h0101, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0101, 16'h0101, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0101, 16'h0101, 0, 0, 0, 1));
        @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);
        // Register 0 hard-wired to zero: writes, claims and collisions on it are ignored.
        apply(mk(1, 1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0), 100);
        apply(mk(0, 1, 1, 0, 16'hFFFF, 0, 0, 16'h0000, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0), 101);
        apply(mk(0, 1, 1, 0, 16'h00FF, 1, 0, 16'h0F0F, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 0, 0), 102);
        apply(mk(0, 1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0), 103);
        apply(mk(0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h00FF, 16'h00FF, 0, 0, 0, 1), 104);
        apply(mk(0, 1, 1, 3, 16'hABCD, 0, 0, 16'h0000, 0, 0, 3, 0, 16'hABCD, 16'h0000, 0, 0, 0, 0), 105);
        apply(mk(0, 1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 3, 0, 16'hABCD, 16'h0000, 0, 0, 0, 0), 106);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
